gelato_warp_dispatcher: RTL and testbench

//  Consumes the kernel-launch request (valid, pc, workers) raised by the top level.

---
 rtl/gelato_pkg.sv | 16 +
 rtl/gelato_prio_enc.sv | 16 +
 rtl/gelato_warp_dispatcher.sv | 139 +++++++++++++
 tb/tb_gelato_warp_dispatcher.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_pkg.sv
// Shared types and sizing for the gelato warp dispatcher.
// The top-level thread capacity THREAD_NUM is WARP_NUM*THREADS_PER_WARP.
package gelato_pkg;
  localparam int WARP_NUM         = 4;
  localparam int THREADS_PER_WARP = 32;
  localparam int ADDR_WIDTH       = 32;
  localparam int WORKER_WIDTH     = 16;
  localparam int THREAD_NUM       = WARP_NUM * THREADS_PER_WARP;

  typedef logic [$clog2(WARP_NUM)-1:0] warp_id_t;
  typedef logic [THREADS_PER_WARP-1:0] warp_mask_t;
  typedef logic [ADDR_WIDTH-1:0]       addr_t;
  typedef logic [WORKER_WIDTH-1:0]     worker_t;

  typedef enum logic [1:0] {IDLE, PICK, SEND} dispatch_state_e;
endpackage

// File: rtl/gelato_prio_enc.sv
// Lowest-set-bit encoder: index of the least significant request plus an any flag.
module gelato_prio_enc #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int i = N-1; i >= 0; i--)
      if (req_i[i]) idx_o = W'(i);
  end
endmodule

// File: rtl/gelato_warp_dispatcher.sv
// Splits a kernel launch into warps and hands each one to a free hardware slot,
// one descriptor per handshake, with lane mask and global thread-id base.
module gelato_warp_dispatcher #(
  parameter int WARP_NUM         = 4,
  parameter int THREADS_PER_WARP = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int WORKER_WIDTH     = 16,
  localparam int IDW = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rdy,
  input  logic                        init_valid,
  output logic                        init_ready,
  input  logic [ADDR_WIDTH-1:0]       init_pc,
  input  logic [WORKER_WIDTH-1:0]     init_workers,
  input  logic [WARP_NUM-1:0]         warp_free,
  output logic                        warp_valid,
  input  logic                        warp_ready,
  output logic [IDW-1:0]              warp_id,
  output logic [ADDR_WIDTH-1:0]       warp_pc,
  output logic [THREADS_PER_WARP-1:0] warp_mask,
  output logic [WORKER_WIDTH-1:0]     warp_tid_base,
  output logic                        launch_done,
  output logic                        launch_err
);
  import gelato_pkg::*;

  localparam int CAP = WARP_NUM * THREADS_PER_WARP;
  localparam int CW  = $clog2(THREADS_PER_WARP) + 1;

  dispatch_state_e               state_q, state_d;
  logic [WORKER_WIDTH-1:0]       remaining_q, remaining_d;
  logic [WARP_NUM-1:0]           claimed_q, claimed_d, cand;
  logic                          valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic [IDW-1:0]                id_q, id_d, pick_id;
  logic [ADDR_WIDTH-1:0]         pc_q, pc_d;
  logic [THREADS_PER_WARP-1:0]   mask_q, mask_d, chunk_mask;
  logic [WORKER_WIDTH-1:0]       tid_q, tid_d;
  logic [CW-1:0]                 chunk;
  logic                          pick_any;

  // A slot stays claimed until the scheduler reports it busy, so it is never reissued early.
  assign cand = warp_free & ~claimed_q;

  gelato_prio_enc #(.N(WARP_NUM)) u_prio (
    .req_i (cand),
    .idx_o (pick_id),
    .any_o (pick_any)
  );

  assign chunk = (remaining_q >= WORKER_WIDTH'(THREADS_PER_WARP)) ? CW'(THREADS_PER_WARP)
                                                                  : CW'(remaining_q);

  // Built bit by bit so a full warp never needs an overflowing shift.
  always_comb begin
    chunk_mask = '0;
    for (int i = 0; i < THREADS_PER_WARP; i++)
      chunk_mask[i] = (CW'(i) < chunk);
  end

  assign init_ready = (state_q == IDLE) & rdy;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    claimed_d   = claimed_q & warp_free;
    valid_d     = valid_q;
    id_d        = id_q;
    pc_d        = pc_q;
    mask_d      = mask_q;
    tid_d       = tid_q;
    err_d       = err_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (init_valid && init_ready) begin
        pc_d  = init_pc;
        tid_d = '0;
        err_d = (32'(init_workers) > 32'(CAP));
        remaining_d = err_d ? WORKER_WIDTH'(CAP) : init_workers;
        if (init_workers == '0) done_d  = 1'b1;
        else                    state_d = PICK;
      end
      PICK: if (pick_any) begin
        id_d    = pick_id;
        mask_d  = chunk_mask;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (warp_ready) begin
        claimed_d[id_q] = 1'b1;
        remaining_d     = remaining_q - WORKER_WIDTH'(chunk);
        tid_d           = tid_q + WORKER_WIDTH'(THREADS_PER_WARP);
        valid_d         = 1'b0;
        if (remaining_d == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = PICK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      claimed_q   <= '0;
      valid_q     <= 1'b0;
      id_q        <= '0;
      pc_q        <= '0;
      mask_q      <= '0;
      tid_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      claimed_q   <= claimed_d;
      valid_q     <= valid_d;
      id_q        <= id_d;
      pc_q        <= pc_d;
      mask_q      <= mask_d;
      tid_q       <= tid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign warp_valid    = valid_q;
  assign warp_id       = id_q;
  assign warp_pc       = pc_q;
  assign warp_mask     = mask_q;
  assign warp_tid_base = tid_q;
  assign launch_done   = done_q;
  assign launch_err    = err_q;
endmodule

// File: tb/tb_gelato_warp_dispatcher.sv
// Bench for gelato_warp_dispatcher: table of launches plus hand-written stall/freeze/reset sequences.
module tb_gelato_warp_dispatcher;
  import gelato_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
  logic       init_valid = 1'b0, warp_ready = 1'b0;
  logic       init_ready, warp_valid, launch_done, launch_err;
  addr_t      init_pc = '0, warp_pc;
  worker_t    init_workers = '0, warp_tid_base;
  logic [WARP_NUM-1:0] warp_free = '0;
  warp_id_t   warp_id;
  warp_mask_t warp_mask;

  int checks = 0, failures = 0, done_cnt = 0, hs_cnt = 0;

  typedef struct {warp_id_t id; addr_t pc; warp_mask_t mask; worker_t base;} desc_t;
  desc_t sb[$];
  desc_t got_e;

  typedef struct {worker_t workers; addr_t pc; int exp_warps; logic exp_err;} vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  gelato_warp_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .init_valid(init_valid), .init_ready(init_ready),
    .init_pc(init_pc), .init_workers(init_workers),
    .warp_free(warp_free), .warp_valid(warp_valid), .warp_ready(warp_ready),
    .warp_id(warp_id), .warp_pc(warp_pc), .warp_mask(warp_mask),
    .warp_tid_base(warp_tid_base), .launch_done(launch_done), .launch_err(launch_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic warp_mask_t ref_mask(input int c);
    logic [63:0] m;
    m = (64'd1 << c) - 64'd1;
    return m[THREADS_PER_WARP-1:0];
  endfunction

  task automatic push_desc(input int id, input addr_t pc, input int c, input int base);
    desc_t d;
    d.id = warp_id_t'(id); d.pc = pc; d.mask = ref_mask(c); d.base = worker_t'(base);
    sb.push_back(d);
  endtask

  // All slots free and unclaimed: warps go to slots 0,1,2,... in order.
  task automatic push_launch(input worker_t w, input addr_t pc);
    int rem, k;
    rem = (int'(w) > THREAD_NUM) ? THREAD_NUM : int'(w);
    k = 0;
    while (rem > 0) begin
      int c;
      c = (rem >= THREADS_PER_WARP) ? THREADS_PER_WARP : rem;
      push_desc(k, pc, c, k * THREADS_PER_WARP);
      rem -= c;
      k++;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rdy) begin
      if (launch_done) done_cnt++;
      if (warp_valid && warp_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL desc_unexpected: got id %0d, expected no descriptor", warp_id);
        end else begin
          got_e = sb.pop_front();
          chk("desc_id", warp_id, got_e.id);
          chk("desc_pc", warp_pc, got_e.pc);
          chk("desc_mask", warp_mask, got_e.mask);
          chk("desc_base", warp_tid_base, got_e.base);
        end
      end
    end
  end

  task automatic do_launch(input vec_t v);
    int cyc, hs0;
    warp_free = '0; step(); warp_free = '1;
    warp_ready = 1'b1;
    push_launch(v.workers, v.pc);
    done_cnt = 0; hs0 = hs_cnt;
    chk("tbl_init_ready", init_ready, 1);
    init_valid = 1'b1; init_pc = v.pc; init_workers = v.workers;
    step();
    init_valid = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 200) begin step(); cyc++; end
    chk("tbl_done_timeout", cyc < 200, 1);
    chk("tbl_warps", hs_cnt - hs0, v.exp_warps);
    chk("tbl_err", launch_err, v.exp_err);
    chk("tbl_sb_empty", sb.size(), 0);
    step();
    chk("tbl_done_once", done_cnt, 1);
    chk("tbl_err_sticky", launch_err, v.exp_err);
    chk("tbl_ready_back", init_ready, 1);
    sb.delete();
  endtask

  initial begin
    int cyc;
    vecs[0] = '{16'd128, 32'h100, 4, 1'b0};
    vecs[1] = '{16'd40,  32'h200, 2, 1'b0};
    vecs[2] = '{16'd0,   32'h300, 0, 1'b0};
    vecs[3] = '{16'd200, 32'h400, 4, 1'b1};
    vecs[4] = '{16'd1,   32'h500, 1, 1'b0};
    vecs[5] = '{16'd33,  32'h600, 2, 1'b0};
    vecs[6] = '{16'd96,  32'h680, 3, 1'b0};
    vecs[7] = '{16'd31,  32'h6C0, 1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", warp_valid, 0);
    chk("rst_id", warp_id, 0);
    chk("rst_pc", warp_pc, 0);
    chk("rst_mask", warp_mask, 0);
    chk("rst_base", warp_tid_base, 0);
    chk("rst_done", launch_done, 0);
    chk("rst_err", launch_err, 0);
    chk("rst_init_ready", init_ready, 1);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) do_launch(vecs[i]);

    // Zero-worker launch: done at N+1, nothing dispatched.
    init_valid = 1'b1; init_workers = 16'd0; init_pc = 32'h900;
    step();
    init_valid = 1'b0;
    chk("zero_done_n1", launch_done, 1);
    chk("zero_no_valid", warp_valid, 0);
    step();
    chk("zero_done_drop", launch_done, 0);
    chk("zero_ready", init_ready, 1);

    // Single free slot with a stalled scheduler.
    warp_free = '0; warp_ready = 1'b0; step();
    warp_free = 4'b0100;
    push_desc(2, 32'h700, 32, 0);
    push_desc(0, 32'h700, 8, 32);
    done_cnt = 0;
    init_valid = 1'b1; init_pc = 32'h700; init_workers = 16'd40;
    step();
    init_valid = 1'b0;
    chk("lat_n1_valid", warp_valid, 0);
    step();
    chk("lat_n2_valid", warp_valid, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", warp_valid, 1);
      chk("stall_id", warp_id, 2);
      chk("stall_mask", warp_mask, 32'hFFFF_FFFF);
      chk("stall_base", warp_tid_base, 0);
      step();
    end
    warp_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("pick_wait", warp_valid, 0);
      step();
    end
    warp_free = 4'b0001;
    cyc = 0;
    while (done_cnt == 0 && cyc < 50) begin step(); cyc++; end
    chk("stall_done_timeout", cyc < 50, 1);
    chk("stall_sb_empty", sb.size(), 0);
    step();

    // rdy freeze mid-SEND, then reset mid-launch.
    warp_free = '0; warp_ready = 1'b0; step();
    warp_free = '1;
    push_desc(0, 32'h800, 32, 0);
    push_desc(1, 32'h800, 32, 32);
    done_cnt = 0;
    init_valid = 1'b1; init_pc = 32'h800; init_workers = 16'd64;
    step();
    init_valid = 1'b0;
    step();
    chk("frz_pre_valid", warp_valid, 1);
    rdy = 1'b0; warp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_valid", warp_valid, 1);
      chk("frz_id", warp_id, 0);
      chk("frz_init_ready", init_ready, 0);
      chk("frz_no_hs", sb.size(), 2);
    end
    rdy = 1'b1;
    step();
    chk("unfrz_hs", sb.size(), 1);
    warp_ready = 1'b0;
    step();
    chk("mid_valid", warp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", warp_valid, 0);
    chk("arst_id", warp_id, 0);
    chk("arst_pc", warp_pc, 0);
    chk("arst_mask", warp_mask, 0);
    chk("arst_base", warp_tid_base, 0);
    chk("arst_err", launch_err, 0);
    chk("arst_init_ready", init_ready, 1);
    sb.delete();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_no_done", done_cnt, 0);
    chk("post_rst_valid", warp_valid, 0);
    chk("post_rst_ready", init_ready, 1);

    do_launch('{16'd70, 32'hA00, 3, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
